// File: rtl/aes_afu_pkg.sv
// Shared types and helpers for the AES AFU read path.
package aes_afu_pkg;
  localparam int LINE_W       = 512;
  localparam int BLK_W        = 128;
  localparam int BLK_PER_LINE = LINE_W / BLK_W;

  typedef logic [LINE_W-1:0] t_line;
  typedef logic [BLK_W-1:0]  t_block;

  // Pointer width: one extra bit beyond the slot address so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Sub-index width, never narrower than one bit.
  function automatic int idx_w(input int blks);
    return (blks > 1) ? $clog2(blks) : 1;
  endfunction
endpackage

// File: rtl/line_to_block_fifo_if.sv
// Line-in / block-out handshake and status bundle of the width-converting FIFO.
interface line_to_block_fifo_if #(
  parameter int LINE_W = aes_afu_pkg::LINE_W,
  parameter int BLK_W  = aes_afu_pkg::BLK_W,
  parameter int DEPTH  = 16
);
  import aes_afu_pkg::*;
  localparam int PW = ptr_w(DEPTH);

  logic [LINE_W-1:0] data_in;
  logic              wr_enable;
  logic [BLK_W-1:0]  data_out;
  logic              rd_enable;
  logic              full;
  logic              empty;
  logic              full_n;
  logic [PW-1:0]     lines_used;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  data_in, wr_enable, rd_enable,
    output data_out, full, empty, full_n, lines_used, overflow, underflow
  );
  modport master (
    output data_in, wr_enable, rd_enable,
    input  data_out, full, empty, full_n, lines_used, overflow, underflow
  );
endinterface

// File: rtl/line_sdp_ram.sv
// Simple dual-port line store: flop array, synchronous write, registered block read.
module line_sdp_ram
  import aes_afu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int LINE_W = aes_afu_pkg::LINE_W,
  parameter int BLK_W  = aes_afu_pkg::BLK_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = idx_w(LINE_W / BLK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [LINE_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  input  logic [BW-1:0]     rb,
  output logic [BLK_W-1:0]  q
);
  logic [LINE_W-1:0] mem [DEPTH];

  // Line storage; no reset so it maps onto plain data flops.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Block select happens before the output register, so read latency is one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (re)  q <= mem[ra][rb*BLK_W +: BLK_W];
  end
endmodule

// File: rtl/line_to_block_fifo.sv
// Cache-line to AES-block width-converting FIFO with almost-full backpressure.
module line_to_block_fifo
  import aes_afu_pkg::*;
#(
  parameter int LINE_W         = aes_afu_pkg::LINE_W,
  parameter int BLK_W          = aes_afu_pkg::BLK_W,
  parameter int DEPTH          = 16,
  parameter int ALM_FULL_SLACK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  line_to_block_fifo_if.slave   bus
);
  localparam int NBLK = LINE_W / BLK_W;
  localparam int PW   = ptr_w(DEPTH);
  localparam int AW   = PW - 1;
  localparam int BW   = idx_w(NBLK);
  localparam logic [BW-1:0] BLK_LAST = BW'(NBLK - 1);

  logic [PW-1:0] wr_ptr, rd_ptr, used;
  logic [BW-1:0] blk_idx;
  logic          full, empty, wr_acc, rd_acc;

  // Flags are decoded from registered pointers only.
  assign used   = wr_ptr - rd_ptr;
  assign empty  = (used == '0);
  assign full   = (used == PW'(DEPTH));
  assign wr_acc = bus.wr_enable && !full  && !clr;
  assign rd_acc = bus.rd_enable && !empty && !clr;

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.full_n     = ((PW'(DEPTH) - used) <= PW'(ALM_FULL_SLACK));
  assign bus.lines_used = used;

  // Pointer and sub-index advance; a slot is freed only after its last block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      blk_idx <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      blk_idx <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        if (blk_idx == BLK_LAST) begin
          blk_idx <= '0;
          rd_ptr  <= rd_ptr + 1'b1;
        end else begin
          blk_idx <= blk_idx + 1'b1;
        end
      end
    end
  end

  // Sticky error flags; judged on pre-edge state, so a concurrent read never rescues a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (clr) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.wr_enable && full)  bus.overflow  <= 1'b1;
      if (bus.rd_enable && empty) bus.underflow <= 1'b1;
    end
  end

  line_sdp_ram #(.DEPTH(DEPTH), .LINE_W(LINE_W), .BLK_W(BLK_W)) u_ram (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .we  (wr_acc),
    .wa  (wr_ptr[AW-1:0]),
    .wd  (bus.data_in),
    .re  (rd_acc),
    .ra  (rd_ptr[AW-1:0]),
    .rb  (blk_idx),
    .q   (bus.data_out)
  );
endmodule

// File: tb/tb_line_to_block_fifo.sv
// Bench: queue-of-lines reference model compared every cycle, plus literal spot checks.
module tb_line_to_block_fifo;
  import aes_afu_pkg::*;
  localparam int DEPTH = 16;
  localparam int SLACK = 4;
  localparam int PW    = ptr_w(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  line_to_block_fifo_if #(.LINE_W(LINE_W), .BLK_W(BLK_W), .DEPTH(DEPTH)) bus ();

  line_to_block_fifo #(.LINE_W(LINE_W), .BLK_W(BLK_W), .DEPTH(DEPTH),
                       .ALM_FULL_SLACK(SLACK)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  // Reference model: queue of whole lines plus how many blocks of the head are consumed.
  t_line  mq[$];
  int     mk;
  t_block m_dout;
  bit     m_ovf, m_unf;
  int     pass_cnt = 0;
  int     total_cnt = 0;

  task automatic model_reset();
    mq.delete();
    mk = 0; m_dout = '0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_edge(input bit wr, input bit rd, input bit c, input t_line ln);
    bit    wacc, racc;
    t_line head;
    if (c) begin
      model_reset();
      return;
    end
    wacc = wr && (mq.size() < DEPTH);
    racc = rd && (mq.size() > 0);
    if (wr && !wacc) m_ovf = 1;
    if (rd && !racc) m_unf = 1;
    if (racc) begin
      head   = mq[0];
      m_dout = head[mk*BLK_W +: BLK_W];
      mk++;
      if (mk == BLK_PER_LINE) begin
        void'(mq.pop_front());
        mk = 0;
      end
    end
    if (wacc) mq.push_back(ln);
  endtask

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic cmp_all();
    int u;
    u = mq.size();
    chk("data_out",   bus.data_out, m_dout);
    chk("lines_used", BLK_W'(bus.lines_used), BLK_W'(u));
    chk("empty",      BLK_W'(bus.empty),  BLK_W'(u == 0));
    chk("full",       BLK_W'(bus.full),   BLK_W'(u == DEPTH));
    chk("full_n",     BLK_W'(bus.full_n), BLK_W'((DEPTH - u) <= SLACK));
    chk("overflow",   BLK_W'(bus.overflow),  BLK_W'(m_ovf));
    chk("underflow",  BLK_W'(bus.underflow), BLK_W'(m_unf));
  endtask

  // One clock: drive, edge, update model, compare on the falling edge.
  task automatic cyc(input bit wr, input bit rd, input bit c, input t_line ln);
    bus.wr_enable = wr;
    bus.rd_enable = rd;
    bus.data_in   = ln;
    clr           = c;
    @(posedge clk);
    model_edge(wr, rd, c, ln);
    @(negedge clk);
    cmp_all();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    clr           = 1'b0;
  endtask

  function automatic t_line mk_line(input int base);
    return {BLK_W'(base + 3), BLK_W'(base + 2), BLK_W'(base + 1), BLK_W'(base)};
  endfunction

  function automatic t_line rnd_line();
    t_line l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    t_line lit;
    bit    w, r, c;
    model_reset();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in   = '0;
    repeat (2) @(negedge clk);
    cmp_all();
    chk("rst_full_n", BLK_W'(bus.full_n), BLK_W'(0));
    rst = 1'b1;
    @(negedge clk);

    // Ordering: lowest block first, one cycle after each read.
    lit = {128'h3, 128'h2, 128'h1, 128'h0};
    cyc(1, 0, 0, lit);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, '0);
      chk("order_blk", bus.data_out, BLK_W'(i));
    end
    chk("order_empty", BLK_W'(bus.empty), BLK_W'(1));

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, mk_line(16 * i + 16));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, '0);
    chk("mid_blk4", bus.data_out, BLK_W'(32));
    #2 rst = 1'b0;
    model_reset();
    #1 cmp_all();
    chk("rst_used", BLK_W'(bus.lines_used), BLK_W'(0));
    chk("rst_dout", bus.data_out, '0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 0, 0, mk_line(100));
    cyc(0, 1, 0, '0);
    chk("post_rst_blk0", bus.data_out, BLK_W'(100));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0);
    chk("post_rst_blk3", bus.data_out, BLK_W'(103));

    // Fill, almost-full, overflow, then read+write while full.
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, mk_line(4 * i + 200));
    chk("alm_full_n", BLK_W'(bus.full_n), BLK_W'(1));
    chk("alm_full",   BLK_W'(bus.full),   BLK_W'(0));
    for (int i = 12; i < 16; i++) cyc(1, 0, 0, mk_line(4 * i + 200));
    chk("fill_full", BLK_W'(bus.full), BLK_W'(1));
    chk("fill_used", BLK_W'(bus.lines_used), BLK_W'(16));
    cyc(1, 0, 0, mk_line(999));
    chk("ovf_set", BLK_W'(bus.overflow), BLK_W'(1));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0);
    chk("full_blk2", bus.data_out, BLK_W'(202));
    cyc(1, 1, 0, mk_line(777));
    chk("full_rw_used", BLK_W'(bus.lines_used), BLK_W'(15));
    chk("full_rw_blk3", bus.data_out, BLK_W'(203));
    while (mq.size() > 0) cyc(0, 1, 0, '0);
    chk("drain_last", bus.data_out, BLK_W'(263));

    // Underflow and no fall-through.
    cyc(0, 0, 1, '0);
    cyc(1, 1, 0, mk_line(300));
    chk("unf_set",  BLK_W'(bus.underflow), BLK_W'(1));
    chk("unf_used", BLK_W'(bus.lines_used), BLK_W'(1));
    chk("unf_dout", bus.data_out, '0);
    cyc(0, 1, 0, '0);
    chk("unf_next", bus.data_out, BLK_W'(300));

    // Occupancy 5: read of a line's last block plus a write keeps the count.
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, mk_line(400 + 4 * i));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0);
    cyc(1, 1, 0, mk_line(500));
    chk("occ5_used", BLK_W'(bus.lines_used), BLK_W'(5));
    chk("occ5_blk",  bus.data_out, BLK_W'(403));

    // Random traffic honoring full/empty, with occasional clears.
    cyc(0, 0, 1, '0);
    for (int n = 0; n < 10000; n++) begin
      w = ($urandom_range(0, 99) < 45) && (mq.size() < DEPTH);
      r = ($urandom_range(0, 99) < 70) && (mq.size() > 0);
      c = ($urandom_range(0, 999) == 0);
      cyc(w, r, c, rnd_line());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
